// File: rtl/alu_arb_pkg.sv
// Shared types and sizing helpers for the ALU request arbiter.
// The issue FSM state is exported so checkers can observe it directly.
package alu_arb_pkg;

    // Requester index width; at least one bit even for a two-requester build.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/alu_arb_id_fifo.sv
// Owner-ID FIFO: remembers which requester issued each in-flight ALU operation.
// Push and pop may happen in the same cycle; pointers wrap naturally.
module alu_arb_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only read while count is nonzero.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters; results are
// routed back in issue order using an owner-ID FIFO.
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int OP_WIDTH        = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b,
    input  logic [NUM_REQ*OP_WIDTH-1:0]    req_op,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [DATA_WIDTH-1:0]          rsp_result,
    output logic                           alu_in_valid,
    input  logic                           alu_in_ready,
    output logic [DATA_WIDTH-1:0]          alu_a,
    output logic [DATA_WIDTH-1:0]          alu_b,
    output logic [OP_WIDTH-1:0]            alu_op,
    input  logic                           alu_out_valid,
    output logic                           alu_out_ready,
    input  logic [DATA_WIDTH-1:0]          alu_result,
    output logic                           err_orphan,
    output state_e                         dbg_state,
    output logic [$clog2(MAX_OUTSTANDING):0] dbg_count
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int CW    = $clog2(MAX_OUTSTANDING) + 1;

    // Handshakes: a transfer happens on a cycle where valid and ready are both
    // high. Once valid rises, it and its payload hold until the matching ready.

    state_e             state;
    state_e             state_nxt;
    logic [IDX_W-1:0]   locked_idx;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   grant_idx;
    logic               issue_fire;
    logic               rsp_fire;
    logic [IDX_W-1:0]   fifo_head;
    logic               fifo_empty;
    logic               fifo_full;
    logic [CW-1:0]      fifo_count;

    // First set bit at or after ptr, searching cyclically.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && valid[idx[IDX_W-1:0]]) begin
                pick  = idx[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign winner = rr_pick(req_valid, rr_ptr);

    // alu_in_valid depends only on state and requests, never on alu_in_ready.
    always_comb begin
        state_nxt    = state;
        grant_idx    = winner;
        alu_in_valid = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_full && (|req_valid)) begin
                    alu_in_valid = 1'b1;
                    if (!alu_in_ready) state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                alu_in_valid = 1'b1;
                grant_idx    = locked_idx;
                if (alu_in_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!rst_n) alu_in_valid = 1'b0;
    end

    assign issue_fire = alu_in_valid && alu_in_ready;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = issue_fire && (grant_idx == IDX_W'(i));
        end
    end

    assign alu_a  = req_a[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign alu_b  = req_b[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign alu_op = req_op[int'(grant_idx)*OP_WIDTH +: OP_WIDTH];

    // Return path: only the owner of the oldest in-flight op sees the result.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = rst_n && alu_out_valid && !fifo_empty && (fifo_head == IDX_W'(i));
        end
    end

    assign rsp_result    = alu_result;
    assign alu_out_ready = rst_n && !fifo_empty && rsp_ready[fifo_head];
    assign rsp_fire      = alu_out_valid && alu_out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            locked_idx <= '0;
            rr_ptr     <= '0;
            err_orphan <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && alu_in_valid && !alu_in_ready) locked_idx <= winner;
            if (issue_fire) begin
                rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
            end
            if (alu_out_valid && fifo_empty) err_orphan <= 1'b1;
        end
    end

    alu_arb_id_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (issue_fire),
        .push_data (grant_idx),
        .pop       (rsp_fire),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign dbg_state = state;
    assign dbg_count = fifo_count;

endmodule
